// File: rtl/fire_alarm_sequencer.sv
// -----------------------------------------------------------------------------
// fire_alarm_sequencer
//
// Sequences the fire-detection datapath: holds the latching detector in reset,
// releases it and waits out an arming holdoff, monitors the detector's final
// alert, and drives the buzzer/LED annunciator pattern.  Operators can silence
// an alarm (ack) and rearm the detector (clear).
//
// Optional feature macro: FIRE_SEQ_ESCALATE_EN
//   When defined, a silenced alarm re-escalates to ALARM after SILENCE_CYCLES
//   if the detector alert is still asserted.  When undefined, SILENCED is left
//   only through clear or reset.
//
// Parameters
//   RST_CYCLES     cycles detector_rst_n is held low per rearm   (1..65535)
//   ARM_CYCLES     post-rearm holdoff ignoring alert_in          (1..65535)
//   BEEP_HALF      half-period of the buzzer/LED pattern         (1..65535)
//   SILENCE_CYCLES silence timeout before re-escalation          (1..65535)
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   alert_in       detector final alert (synchronous to clk)
//   ack_in         operator silence level, acts on rising edge
//   clear_in       operator rearm level, acts on rising edge
//   detector_rst_n active-low reset to the detector (registered)
//   buzzer_out     buzzer drive (registered)
//   led_out        alarm LED drive (registered)
//   state_out      current state encoding (registered)
//   alarm_count    saturating count of alarm entries (registered)
// -----------------------------------------------------------------------------
module fire_alarm_sequencer #(
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned ARM_CYCLES     = 16,
    parameter int unsigned BEEP_HALF      = 8,
    parameter int unsigned SILENCE_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alert_in,
    input  logic       ack_in,
    input  logic       clear_in,
    output logic       detector_rst_n,
    output logic       buzzer_out,
    output logic       led_out,
    output logic [2:0] state_out,
    output logic [7:0] alarm_count
);

    typedef enum logic [2:0] {
        S_RESET_DET = 3'd0,
        S_ARM       = 3'd1,
        S_MONITOR   = 3'd2,
        S_ALARM     = 3'd3,
        S_SILENCED  = 3'd4
    } state_t;

    localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] ARM_LAST  = 16'(ARM_CYCLES - 1);
    localparam logic [15:0] BEEP_LAST = 16'(BEEP_HALF - 1);
    localparam logic [15:0] SIL_LAST  = 16'(SILENCE_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] beep_q;
    logic [15:0] beep_d;
    logic        phase_q;
    logic        phase_d;
    logic        ack_q;
    logic        clear_q;
    logic [7:0]  count_q;
    logic [7:0]  count_d;
    logic        det_q;
    logic        det_d;
    logic        buzzer_q;
    logic        buzzer_d;
    logic        led_q;
    logic        led_d;
    logic        ack_rise_s;
    logic        clear_rise_s;
    logic        entering_s;

    // Rising-edge detection of the operator levels against last cycle's sample.
    always_comb begin
        ack_rise_s   = ack_in & ~ack_q;
        clear_rise_s = clear_in & ~clear_q;
    end

    // Next-state decision and saturating alarm-entry counter.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_RESET_DET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_ARM;
                end else begin
                    state_d = S_RESET_DET;
                end
            end
            S_ARM: begin
                if (cnt_q == ARM_LAST) begin
                    state_d = S_MONITOR;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_MONITOR: begin
                if (clear_rise_s) begin
                    state_d = S_RESET_DET;
                end else if (alert_in) begin
                    state_d = S_ALARM;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    state_d = S_MONITOR;
                end
            end
            S_ALARM: begin
                // Clear has priority over ack when both rise together.
                if (clear_rise_s) begin
                    state_d = S_RESET_DET;
                end else if (ack_rise_s) begin
                    state_d = S_SILENCED;
                end else begin
                    state_d = S_ALARM;
                end
            end
            S_SILENCED: begin
                if (clear_rise_s) begin
                    state_d = S_RESET_DET;
`ifdef FIRE_SEQ_ESCALATE_EN
                end else if ((cnt_q == SIL_LAST) && alert_in) begin
                    // Re-escalation is not a new alarm entry: count untouched.
                    state_d = S_ALARM;
`endif
                end else begin
                    state_d = S_SILENCED;
                end
            end
            default: begin
                state_d = S_RESET_DET;
            end
        endcase
    end

    // Phase counter and beep timer; both restart whenever a state is entered.
    always_comb begin
        entering_s = (state_d != state_q);
        if (entering_s) begin
            cnt_d = 16'd0;
        end else if ((state_q == S_SILENCED) && (cnt_q == SIL_LAST)) begin
            // Park at the silence timeout so a late alert can still escalate.
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        if (entering_s) begin
            beep_d  = 16'd0;
            phase_d = 1'b0;
        end else if ((state_q == S_ALARM) || (state_q == S_SILENCED)) begin
            if (beep_q == BEEP_LAST) begin
                beep_d  = 16'd0;
                phase_d = ~phase_q;
            end else begin
                beep_d  = beep_q + 16'd1;
                phase_d = phase_q;
            end
        end else begin
            beep_d  = 16'd0;
            phase_d = 1'b0;
        end
    end

    // Output decode from the upcoming state so the pins are registered yet
    // change on the same edge as state_out.
    always_comb begin
        det_d    = 1'b0;
        buzzer_d = 1'b0;
        led_d    = 1'b0;
        case (state_d)
            S_RESET_DET: begin
                det_d = 1'b0;
            end
            S_ARM, S_MONITOR: begin
                det_d = 1'b1;
            end
            S_ALARM: begin
                det_d    = 1'b1;
                buzzer_d = ~phase_d;
                led_d    = 1'b1;
            end
            S_SILENCED: begin
                det_d = 1'b1;
                led_d = ~phase_d;
            end
            default: begin
                det_d = 1'b0;
            end
        endcase
    end

    // State, timers, edge-detect history, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RESET_DET;
            cnt_q    <= 16'd0;
            beep_q   <= 16'd0;
            phase_q  <= 1'b0;
            ack_q    <= 1'b0;
            clear_q  <= 1'b0;
            count_q  <= 8'd0;
            det_q    <= 1'b0;
            buzzer_q <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beep_q   <= beep_d;
            phase_q  <= phase_d;
            ack_q    <= ack_in;
            clear_q  <= clear_in;
            count_q  <= count_d;
            det_q    <= det_d;
            buzzer_q <= buzzer_d;
            led_q    <= led_d;
        end
    end

    assign detector_rst_n = det_q;
    assign buzzer_out     = buzzer_q;
    assign led_out        = led_q;
    assign state_out      = state_q;
    assign alarm_count    = count_q;

endmodule

// File: tb/tb_fire_alarm_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for fire_alarm_sequencer.  A behavioural model tracks the mode and
// the time spent in it; the annunciator pattern is derived arithmetically from
// that time.  Each scenario task drives stimulus and compares inline.
// -----------------------------------------------------------------------------
module tb_fire_alarm_sequencer;

    localparam int RST  = 4;
    localparam int ARMC = 16;
    localparam int BH   = 8;
    localparam int SIL  = 64;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       alert_in = 1'b0;
    logic       ack_in   = 1'b0;
    logic       clear_in = 1'b0;
    logic       detector_rst_n;
    logic       buzzer_out;
    logic       led_out;
    logic [2:0] state_out;
    logic [7:0] alarm_count;

    int total = 0;
    int bad   = 0;

    // Model: mode (0..4), cycles since mode entry, alarm entries, last levels.
    int m_state;
    int m_t;
    int m_count;
    bit m_ack;
    bit m_clr;

    logic [13:0] dut_vec;
    assign dut_vec = {detector_rst_n, buzzer_out, led_out, state_out, alarm_count};

    fire_alarm_sequencer #(
        .RST_CYCLES    (RST),
        .ARM_CYCLES    (ARMC),
        .BEEP_HALF     (BH),
        .SILENCE_CYCLES(SIL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alert_in      (alert_in),
        .ack_in        (ack_in),
        .clear_in      (clear_in),
        .detector_rst_n(detector_rst_n),
        .buzzer_out    (buzzer_out),
        .led_out       (led_out),
        .state_out     (state_out),
        .alarm_count   (alarm_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0;
        m_t     = 0;
        m_count = 0;
        m_ack   = 1'b0;
        m_clr   = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_step();
        bit ar;
        bit cr;
        int ns;
        ar = ack_in && !m_ack;
        cr = clear_in && !m_clr;
        ns = m_state;
        case (m_state)
            0: if (m_t == RST - 1) ns = 1;
            1: if (m_t == ARMC - 1) ns = 2;
            2: begin
                if (cr) ns = 0;
                else if (alert_in) begin
                    ns = 3;
                    if (m_count < 255) m_count = m_count + 1;
                end
            end
            3: begin
                if (cr) ns = 0;
                else if (ar) ns = 4;
            end
            4: begin
                if (cr) ns = 0;
`ifdef FIRE_SEQ_ESCALATE_EN
                else if ((m_t >= SIL - 1) && alert_in) ns = 3;
`endif
            end
            default: ns = 0;
        endcase
        if (ns != m_state) m_t = 0;
        else m_t = m_t + 1;
        m_state = ns;
        m_ack   = ack_in;
        m_clr   = clear_in;
    endtask

    function automatic logic [13:0] exp_vec();
        bit   ph;
        logic det;
        logic bz;
        logic ld;
        ph  = ((m_t / BH) % 2) != 0;
        det = (m_state != 0);
        bz  = (m_state == 3) && !ph;
        ld  = (m_state == 3) || ((m_state == 4) && !ph);
        return {det, bz, ld, 3'(m_state), 8'(m_count)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Rearm the detector and wait (bounded) for an alarm with alert held.
    task automatic go_alarm();
        int n;
        clear_in = 1'b0;
        ack_in   = 1'b0;
        step();
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        alert_in = 1'b1;
        n = 0;
        while ((m_state != 3) && (n < 60)) begin
            step();
            n++;
        end
        total++;
        if (dut_vec !== exp_vec() || state_out !== 3'd3) begin
            bad++;
            $display("FAIL go_alarm: got %h want %h after %0d cycles", dut_vec, exp_vec(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dut_vec !== 14'd0) begin
            bad++;
            $display("FAIL reset_values: got %h want %h", dut_vec, 14'd0);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_bringup();
        for (int i = 1; i <= 21; i++) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL bringup_c%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == 3 || i == 4 || i == 20 || i == 21) begin
                total++;
                if ({detector_rst_n, state_out} !==
                    ((i == 3) ? 4'h0 : (i == 4) ? 4'h9 : (i == 20) ? 4'hA : 4'hB)) begin
                    bad++;
                    $display("FAIL bringup_edge%0d: got det=%b st=%0d", i, detector_rst_n, state_out);
                end
            end
            // Alert raised during ARM must be ignored until MONITOR.
            if (i == 10) alert_in = 1'b1;
        end
    endtask

    task automatic test_alarm();
        for (int k = 1; k <= 40; k++) begin
            step();
            total++;
            if (dut_vec !== exp_vec() || buzzer_out !== (((k / 8) % 2) == 0) || led_out !== 1'b1) begin
                bad++;
                $display("FAIL alarm_pattern_k%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_ack();
        ack_in = 1'b1;
        for (int i = 0; i < 42; i++) begin
            if (i == 30) ack_in = 1'b0;
            if (i == 36) ack_in = 1'b1;
            step();
            total++;
            if (dut_vec !== exp_vec() || buzzer_out !== 1'b0 || state_out !== 3'd4) begin
                bad++;
                $display("FAIL ack_silence_c%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        ack_in = 1'b0;
    endtask

    task automatic test_ack_clear();
        int c0;
        go_alarm();
        c0 = m_count;
        ack_in   = 1'b1;
        clear_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (dut_vec !== exp_vec() || alarm_count !== 8'(c0) ||
                detector_rst_n !== (i >= 4)) begin
                bad++;
                $display("FAIL ack_clear_c%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        ack_in   = 1'b0;
        clear_in = 1'b0;
    endtask

    task automatic test_escalate();
        int c0;
        int n;
        go_alarm();
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        c0 = m_count;
`ifdef FIRE_SEQ_ESCALATE_EN
        n = 70;
`else
        n = 1000;
`endif
        for (int i = 1; i <= n; i++) begin
            step();
            total++;
            if (dut_vec !== exp_vec() || alarm_count !== 8'(c0)) begin
                bad++;
                $display("FAIL escalate_c%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == 64 || i == n) begin
                total++;
`ifdef FIRE_SEQ_ESCALATE_EN
                if (state_out !== 3'd3) begin
`else
                if (state_out !== 3'd4) begin
`endif
                    bad++;
                    $display("FAIL escalate_state_c%0d: got %0d", i, state_out);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            alert_in = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) ack_in = ~ack_in;
            if ($urandom_range(0, 40) == 0) clear_in = ~clear_in;
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random_c%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        ack_in   = 1'b0;
        clear_in = 1'b0;
        alert_in = 1'b0;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 256; i++) begin
            go_alarm();
        end
        total++;
        if (alarm_count !== 8'd255 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL saturate: got %h want count 255 vec %h", dut_vec, exp_vec());
        end
        // Asynchronous reset between edges, mid-ALARM.
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (dut_vec !== 14'd0) begin
            bad++;
            $display("FAIL async_reset: got %h want %h", dut_vec, 14'd0);
        end
        model_reset();
        alert_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL post_reset_c%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bringup();
        test_alarm();
        test_ack();
        test_ack_clear();
        test_escalate();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
